// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one SRAM-like memory port between instruction fetch and data requesters,
// one outstanding transaction at a time. Define MEMARB_RR_EN for round-robin arbitration
// instead of fixed data-over-instruction priority.
module mem_port_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inst_req,
    input  logic [AW-1:0] inst_addr,
    output logic [DW-1:0] inst_rdata,
    output logic          inst_ok,
    input  logic          data_req,
    input  logic          data_wr,
    input  logic [3:0]    data_wen,
    input  logic [AW-1:0] data_addr,
    input  logic [DW-1:0] data_wdata,
    output logic [DW-1:0] data_rdata,
    output logic          data_ok,
    output logic          mem_req,
    output logic          mem_wr,
    output logic [3:0]    mem_wen,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_addr_ok,
    input  logic          mem_data_ok,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_wr_q, mem_wr_d;
    logic [3:0]    mem_wen_q, mem_wen_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] inst_rdata_q, inst_rdata_d;
    logic [DW-1:0] data_rdata_q, data_rdata_d;
    logic          inst_ok_q, inst_ok_d;
    logic          data_ok_q, data_ok_d;
    logic          busy_q, busy_d;
    logic          any_req;
    logic          grant_data;

    assign any_req = inst_req | data_req;

`ifdef MEMARB_RR_EN
    logic last_q, last_d;

    // last_q is 1 when data won the most recent grant; a tie goes to the other requester
    assign grant_data = data_req & (~inst_req | ~last_q);
    assign last_d     = (state_q == IDLE && any_req) ? grant_data : last_q;

    // remember the previous winner, starting as if instruction fetch had just won
    always_ff @(posedge clk) begin
        if (rst) last_q <= 1'b0;
        else     last_q <= last_d;
    end
`else
    assign grant_data = data_req;
`endif

    // next-state and registered-output logic for the single-outstanding transaction FSM
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        mem_req_d    = mem_req_q;
        mem_wr_d     = mem_wr_q;
        mem_wen_d    = mem_wen_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        inst_ok_d    = 1'b0;
        data_ok_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d     = ADDR;
                    owner_d     = grant_data;
                    mem_req_d   = 1'b1;
                    mem_wr_d    = grant_data & data_wr;
                    mem_wen_d   = (grant_data & data_wr) ? data_wen : 4'b0000;
                    mem_addr_d  = grant_data ? data_addr : inst_addr;
                    mem_wdata_d = grant_data ? data_wdata : '0;
                end
            end
            ADDR: begin
                if (mem_addr_ok) begin
                    mem_req_d = 1'b0;
                    state_d   = mem_data_ok ? RESP : DATA;
                end
            end
            DATA: begin
                if (mem_data_ok) state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
        if (state_d == RESP) begin
            inst_ok_d    = ~owner_q;
            data_ok_d    = owner_q;
            inst_rdata_d = owner_q ? inst_rdata_q : mem_rdata;
            data_rdata_d = owner_q ? mem_rdata : data_rdata_q;
        end
        busy_d = (state_d != IDLE);
    end

    // state and output registers; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_wen_q    <= 4'b0000;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
            inst_ok_q    <= 1'b0;
            data_ok_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            mem_req_q    <= mem_req_d;
            mem_wr_q     <= mem_wr_d;
            mem_wen_q    <= mem_wen_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
            inst_ok_q    <= inst_ok_d;
            data_ok_q    <= data_ok_d;
            busy_q       <= busy_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_wr     = mem_wr_q;
    assign mem_wen    = mem_wen_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign inst_rdata = inst_rdata_q;
    assign data_rdata = data_rdata_q;
    assign inst_ok    = inst_ok_q;
    assign data_ok    = data_ok_q;
    assign busy       = busy_q;

endmodule
